// File: rtl/register_load_arbiter.sv
// rtl/register_load_arbiter.sv - round-robin arbiter sharing one falling-edge load-enable register
// Grants one requester per write, drives reg_d/Enbar for one Clkbar cycle, then acks.
module register_load_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                   Clkbar,
   input  logic                   Resetbar,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]       reg_d,
   output logic                   Enbar,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       ack,
   output logic                   busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] reg_d_q,  reg_d_d;
   logic             enbar_q,  enbar_d;
   logic [N_REQ-1:0] grant_q,  grant_d;
   logic [N_REQ-1:0] ack_q,    ack_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] owner_q,  owner_d;

   logic             win_found;
   logic [PTR_W-1:0] win_idx;
   logic [WIDTH-1:0] win_data;
   int               cand;

   // Search starts at rr_ptr so the previous winner is scanned last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   assign win_data = data_in[int'(win_idx)*WIDTH +: WIDTH];

   always_comb begin
      state_d  = state_q;
      reg_d_d  = reg_d_q;
      enbar_d  = enbar_q;
      grant_d  = grant_q;
      ack_d    = ack_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      case (state_q)
         ST_IDLE: begin
            enbar_d = 1'b1;
            if (win_found) begin
               state_d = ST_LOAD;
               reg_d_d = win_data;
               grant_d = ONE_HOT0 << win_idx;
               owner_d = win_idx;
               enbar_d = 1'b0;
            end
         end
         ST_LOAD: begin
            state_d = ST_ACK;
            enbar_d = 1'b1;
            ack_d   = grant_q;
         end
         ST_ACK: begin
            state_d  = ST_IDLE;
            ack_d    = '0;
            grant_d  = '0;
            rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            enbar_d = 1'b1;
            grant_d = '0;
            ack_d   = '0;
         end
      endcase
   end

   always_ff @(negedge Clkbar or negedge Resetbar) begin
      if (!Resetbar) begin
         state_q  <= ST_IDLE;
         reg_d_q  <= '0;
         enbar_q  <= 1'b1;
         grant_q  <= '0;
         ack_q    <= '0;
         rr_ptr_q <= '0;
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         reg_d_q  <= reg_d_d;
         enbar_q  <= enbar_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   assign reg_d = reg_d_q;
   assign Enbar = enbar_q;
   assign grant = grant_q;
   assign ack   = ack_q;
   assign busy  = (state_q == ST_LOAD) || (state_q == ST_ACK);

endmodule

// File: tb/tb_register_load_arbiter.sv
// tb/tb_register_load_arbiter.sv - directed self-checking bench for register_load_arbiter
// The shared falling-edge load-enable register is modelled locally as reg_out.
module tb_register_load_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;

   logic                   Clkbar = 1'b1;
   logic                   Resetbar;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] data_in;
   logic [WIDTH-1:0]       reg_d;
   logic                   Enbar;
   logic [N_REQ-1:0]       grant;
   logic [N_REQ-1:0]       ack;
   logic                   busy;
   logic [7:0]             reg_out = 8'h00;

   int checks = 0;
   int errors = 0;

   register_load_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .Clkbar   (Clkbar),
      .Resetbar (Resetbar),
      .req      (req),
      .data_in  (data_in),
      .reg_d    (reg_d),
      .Enbar    (Enbar),
      .grant    (grant),
      .ack      (ack),
      .busy     (busy)
   );

   always #5 Clkbar = ~Clkbar;

   always @(negedge Clkbar) begin
      if (Enbar === 1'b0) begin
         reg_out <= reg_d;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clkbar);
      #1;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      data_in[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic wait_ack();
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 12; t++) begin
         cyc();
         if (ack !== '0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $error("FAIL ack_timeout: observed no ack expected ack within 12 cycles");
      end
   endtask

   initial begin
      logic [3:0] exp_ack;
      logic [7:0] exp_val;

      Resetbar = 1'b0;
      req      = '0;
      data_in  = '0;

      // Reset state
      cyc();
      chk("rst_enbar", Enbar, 1);
      chk("rst_grant", grant, 0);
      chk("rst_ack",   ack,   0);
      chk("rst_reg_d", reg_d, 0);
      chk("rst_busy",  busy,  0);
      Resetbar = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("idle_enbar", Enbar, 1);
      end
      chk("idle_grant", grant, 0);

      // Single request from requester 2
      set_data(2, 8'hA5);
      req = 4'b0100;
      cyc();
      chk("single_load_enbar", Enbar, 0);
      chk("single_load_grant", grant, 4'b0100);
      chk("single_load_ack",   ack,   0);
      chk("single_load_busy",  busy,  1);
      chk("single_load_reg_d", reg_d, 8'hA5);
      cyc();
      chk("single_ack_enbar", Enbar, 1);
      chk("single_ack_ack",   ack,   4'b0100);
      chk("single_ack_grant", grant, 4'b0100);
      chk("single_ack_reg",   reg_out, 8'hA5);
      req = 4'b0000;
      cyc();
      chk("single_done_ack",   ack,   0);
      chk("single_done_grant", grant, 0);
      chk("single_done_busy",  busy,  0);
      cyc();
      chk("single_idle_enbar", Enbar, 1);

      // Fairness from rr_ptr=0 with all four requesting
      Resetbar = 1'b0;
      cyc();
      Resetbar = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_data(i, 8'h10 + 8'(i));
      end
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp_ack = 4'b0001 << (n % 4);
         exp_val = 8'h10 + 8'(n % 4);
         wait_ack();
         chk("fair_ack",   ack,     exp_ack);
         chk("fair_grant", grant,   exp_ack);
         chk("fair_reg",   reg_out, exp_val);
      end
      req = 4'b0000;
      cyc();
      cyc();

      // Reset while Enbar is low: load aborted, register keeps 8'h10
      set_data(1, 8'h77);
      req = 4'b0010;
      cyc();
      chk("midload_enbar_low", Enbar, 0);
      Resetbar = 1'b0;
      #1;
      chk("midload_rst_enbar", Enbar, 1);
      chk("midload_rst_grant", grant, 0);
      chk("midload_rst_reg_d", reg_d, 0);
      chk("midload_rst_busy",  busy,  0);
      req = 4'b0000;
      cyc();
      chk("midload_rst_ack", ack,     0);
      chk("midload_rst_reg", reg_out, 8'h10);
      Resetbar = 1'b1;

      // rr_ptr back at 0 picks requester 0 over 3; data change after grant ignored
      set_data(0, 8'h3C);
      set_data(3, 8'hEE);
      req = 4'b1001;
      cyc();
      chk("ptr0_grant", grant, 4'b0001);
      set_data(0, 8'hFF);
      cyc();
      chk("datachg_ack", ack,     4'b0001);
      chk("datachg_reg", reg_out, 8'h3C);
      req = 4'b0000;
      cyc();
      cyc();

      // Advance rr_ptr to 3 via requester 2, then wrap 3 -> 0
      req = 4'b0100;
      cyc();
      cyc();
      chk("pre_wrap_ack", ack, 4'b0100);
      req = 4'b0000;
      cyc();
      set_data(3, 8'h5A);
      set_data(0, 8'hC3);
      req = 4'b1001;
      cyc();
      chk("wrap_grant3", grant, 4'b1000);
      req = 4'b0001;
      cyc();
      chk("wrap_ack3", ack,     4'b1000);
      chk("wrap_reg3", reg_out, 8'h5A);
      cyc();
      chk("wrap_ack3_gone", ack, 0);
      cyc();
      chk("wrap_grant0", grant, 4'b0001);
      cyc();
      chk("wrap_ack0", ack,     4'b0001);
      chk("wrap_reg0", reg_out, 8'hC3);
      req = 4'b0000;
      cyc();
      cyc();
      chk("final_enbar", Enbar, 1);
      chk("final_grant", grant, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
